// File: rtl/panel_btn_decoder_if.sv
// Front-panel decoder bus: raw button/switch inputs and the conditioned strobes/levels.
// master = panel/stimulus side, slave = decoder side.
interface panel_btn_decoder_if;
  logic [3:0] btn_in;
  logic [3:0] sw_in;
  logic       sys_init;
  logic       trg;
  logic       rst;
  logic       wrk_stat;
  logic [3:0] rf_sw_sel;
  logic [3:0] btn_state;

  modport master (
    output btn_in, sw_in,
    input  sys_init, trg, rst, wrk_stat, rf_sw_sel, btn_state
  );

  modport slave (
    input  btn_in, sw_in,
    output sys_init, trg, rst, wrk_stat, rf_sw_sel, btn_state
  );
endinterface

// File: rtl/panel_btn_decoder.sv
// Synchronises, debounces and edge-detects front-panel buttons and DIP switches.
// Optional macro LONG_PRESS_EN: holding the rst button LONG_CYCLES cycles also fires sys_init.
module panel_btn_decoder #(
  parameter int unsigned DB_W        = 16,
  parameter int unsigned DB_CYCLES   = 50000,
  parameter int unsigned LONG_W      = 27,
  parameter int unsigned LONG_CYCLES = 100000000
) (
  input logic                fpga_clk,
  input logic                sys_init_ctrl_n,
  panel_btn_decoder_if.slave bus
);
  localparam int unsigned N_BTN    = 4;
  localparam int unsigned N_CH     = 8;
  localparam int unsigned BTN_RUN  = 0;
  localparam int unsigned BTN_RST  = 1;
  localparam int unsigned BTN_TRG  = 2;
  localparam int unsigned BTN_INIT = 3;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Elaboration-time range checks on the counter sizing
  if (DB_CYCLES < 1 || 64'(DB_CYCLES) >= (64'(1) << DB_W)) begin : g_bad_db
    $error("DB_CYCLES does not fit DB_W");
  end
  if (LONG_CYCLES < 1 || 64'(LONG_CYCLES) >= (64'(1) << LONG_W)) begin : g_bad_long
    $error("LONG_CYCLES does not fit LONG_W");
  end

  logic [N_CH-1:0]  sync_q1;
  logic [N_CH-1:0]  sync_q2;
  logic [N_CH-1:0]  stable;
  logic [N_CH-1:0]  stable_nxt;
  logic [N_BTN-1:0] stable_q;
  logic [DB_W-1:0]  cnt     [N_CH];
  logic [DB_W-1:0]  cnt_nxt [N_CH];
  logic [N_BTN-1:0] rise_c;
  logic             long_hit_c;
  logic             wrk_stat_nxt;
  logic             sys_init_r;
  logic             trg_r;
  logic             rst_r;
  logic             wrk_stat_r;

  // Per-channel debounce: accept a new level after DB_CYCLES consecutive mismatches
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
      if (sync_q2[i] != stable[i]) begin
        if (cnt[i] == DB_LAST) stable_nxt[i] = sync_q2[i];
        else                   cnt_nxt[i]    = cnt[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      sync_q1  <= {bus.sw_in, bus.btn_in};
      sync_q2  <= sync_q1;
      stable   <= stable_nxt;
      stable_q <= stable[N_BTN-1:0];
      for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  logic [LONG_W-1:0] long_cnt;
  logic [LONG_W-1:0] long_cnt_nxt;

  // Counter parks one past LONG_LAST so the hit fires only once per hold
  always_comb begin
    long_cnt_nxt = long_cnt;
    long_hit_c   = 1'b0;
    if (!stable[BTN_RST]) begin
      long_cnt_nxt = '0;
    end else if (long_cnt <= LONG_LAST) begin
      long_cnt_nxt = long_cnt + LONG_W'(1);
      long_hit_c   = (long_cnt == LONG_LAST);
    end
  end

  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) long_cnt <= '0;
    else                  long_cnt <= long_cnt_nxt;
  end
`else
  assign long_hit_c = 1'b0;
`endif

  // Press edges and run-level update; a reset-type pulse beats a run toggle
  always_comb begin
    rise_c       = stable[N_BTN-1:0] & ~stable_q;
    wrk_stat_nxt = wrk_stat_r;
    if (rise_c[BTN_INIT] || rise_c[BTN_RST] || long_hit_c) wrk_stat_nxt = 1'b0;
    else if (rise_c[BTN_RUN])                              wrk_stat_nxt = ~wrk_stat_r;
  end

  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      sys_init_r <= 1'b0;
      trg_r      <= 1'b0;
      rst_r      <= 1'b0;
      wrk_stat_r <= 1'b0;
    end else begin
      sys_init_r <= rise_c[BTN_INIT] | long_hit_c;
      trg_r      <= rise_c[BTN_TRG];
      rst_r      <= rise_c[BTN_RST];
      wrk_stat_r <= wrk_stat_nxt;
    end
  end

  assign bus.sys_init  = sys_init_r;
  assign bus.trg       = trg_r;
  assign bus.rst       = rst_r;
  assign bus.wrk_stat  = wrk_stat_r;
  assign bus.btn_state = stable[N_BTN-1:0];
  assign bus.rf_sw_sel = stable[N_CH-1:N_BTN];
endmodule

// File: tb/tb_panel_btn_decoder.sv
// Scoreboard bench for panel_btn_decoder: a history-window reference model predicts levels
// and pulse events per edge; an independent monitor pops and compares them.
module tb_panel_btn_decoder;
  localparam int unsigned DB   = 4;
  localparam int unsigned LONG = 20;
  localparam int          MAXE = 4096;
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic fpga_clk = 1'b0;
  logic sys_init_ctrl_n;

  panel_btn_decoder_if bus_if ();

  panel_btn_decoder #(
    .DB_W(16), .DB_CYCLES(DB), .LONG_W(27), .LONG_CYCLES(LONG)
  ) dut (
    .fpga_clk        (fpga_clk),
    .sys_init_ctrl_n (sys_init_ctrl_n),
    .bus             (bus_if)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    int         edge_n;
    logic [3:0] btn;
    logic [3:0] sw;
    logic       wrk;
  } snap_t;

  typedef struct {
    int         edge_n;
    logic [2:0] pulses;  // {sys_init, trg, rst}
  } evt_t;

  snap_t snap_q[$];
  evt_t  evt_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state: raw samples and debounced levels, indexed by edge since reset
  logic [7:0] raw_hist [MAXE];
  logic [7:0] st_hist  [MAXE];
  int         last_flip [8];
  int         e;
  logic       m_wrk;

  int trg_seen = 0;
  int sinit_seen = 0;
  int last_trg_edge = -1;
  logic [7:0] cur_raw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int edg);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edg);
    end
  endtask

  // Value seen by the debouncer at edge k: raw sampled two edges earlier, 0 while sync flops hold reset
  function automatic logic [7:0] dval(input int k);
    return (k >= 3) ? raw_hist[k-2] : 8'h00;
  endfunction

  task automatic model_reset();
    e = 0;
    st_hist[0] = 8'h00;
    for (int b = 0; b < 8; b++) last_flip[b] = 0;
    m_wrk = 1'b0;
    snap_q.delete();
    evt_q.delete();
  endtask

  task automatic model_step(input logic [7:0] raw);
    logic [7:0] d;
    logic [3:0] rise;
    logic       lng, ok;
    logic [2:0] p;
    snap_t      s;
    evt_t       ev;
    e++;
    raw_hist[e] = raw;
    st_hist[e]  = st_hist[e-1];
    // A level is accepted when the last DB observations since the previous change all disagree with it
    for (int b = 0; b < 8; b++) begin
      if (e - last_flip[b] >= int'(DB)) begin
        ok = 1'b1;
        for (int j = 0; j < int'(DB); j++) begin
          d = dval(e - j);
          if (d[b] == st_hist[e-1][b]) ok = 1'b0;
        end
        if (ok) begin
          st_hist[e][b] = ~st_hist[e-1][b];
          last_flip[b]  = e;
        end
      end
    end
    rise = (e >= 2) ? (st_hist[e-1][3:0] & ~st_hist[e-2][3:0]) : 4'h0;
    lng = 1'b0;
    if (LONG_ON && e - int'(LONG) >= 1) begin
      lng = ~st_hist[e-int'(LONG)-1][1];
      for (int k = e - int'(LONG); k < e; k++) if (!st_hist[k][1]) lng = 1'b0;
    end
    p = {rise[3] | lng, rise[2], rise[1]};
    if (p[2] || p[0])  m_wrk = 1'b0;
    else if (rise[0])  m_wrk = ~m_wrk;
    s.edge_n = e; s.btn = st_hist[e][3:0]; s.sw = st_hist[e][7:4]; s.wrk = m_wrk;
    snap_q.push_back(s);
    if (p != 3'b000) begin
      ev.edge_n = e; ev.pulses = p;
      evt_q.push_back(ev);
    end
  endtask

  task automatic cycle(input logic [3:0] btn, input logic [3:0] sw);
    @(negedge fpga_clk); #1;
    bus_if.btn_in = btn;
    bus_if.sw_in  = sw;
    cur_raw = {sw, btn};
    model_step({sw, btn});
  endtask

  task automatic hold(input logic [3:0] btn, input logic [3:0] sw, input int n);
    for (int i = 0; i < n; i++) cycle(btn, sw);
  endtask

  task automatic do_reset(input int n, input bit rnd, input logic [3:0] btn, input logic [3:0] sw);
    @(negedge fpga_clk); #1;
    sys_init_ctrl_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge fpga_clk); #1;
      bus_if.btn_in = rnd ? 4'($urandom) : btn;
      bus_if.sw_in  = rnd ? 4'($urandom) : sw;
    end
    @(negedge fpga_clk); #1;
    sys_init_ctrl_n = 1'b1;
    bus_if.btn_in = btn;
    bus_if.sw_in  = sw;
    cur_raw = {sw, btn};
    model_step({sw, btn});
  endtask

  task automatic random_run(input int n);
    logic [7:0] r;
    r = cur_raw;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      cycle(r[3:0], r[7:4]);
    end
  endtask

  // Monitor: checks levels every edge and pops a pulse event whenever the DUT pulses
  snap_t      ms;
  evt_t       mev;
  logic [2:0] mpul;
  always @(negedge fpga_clk) begin
    mpul = {bus_if.sys_init, bus_if.trg, bus_if.rst};
    if (!sys_init_ctrl_n) begin
      chk("reset_outs", {20'h0, mpul, bus_if.wrk_stat, bus_if.rf_sw_sel, bus_if.btn_state}, 32'h0, -1);
    end else if (snap_q.size() > 0) begin
      ms = snap_q.pop_front();
      chk("btn_state", 32'(bus_if.btn_state), 32'(ms.btn), ms.edge_n);
      chk("rf_sw_sel", 32'(bus_if.rf_sw_sel), 32'(ms.sw), ms.edge_n);
      chk("wrk_stat",  32'(bus_if.wrk_stat),  32'(ms.wrk), ms.edge_n);
      while (evt_q.size() > 0 && evt_q[0].edge_n < ms.edge_n) begin
        mev = evt_q.pop_front();
        chk("missed_pulse", 32'h0, 32'(mev.pulses), mev.edge_n);
      end
      if (mpul != 3'b000) begin
        if (bus_if.trg) begin trg_seen++; last_trg_edge = ms.edge_n; end
        if (bus_if.sys_init) sinit_seen++;
        if (evt_q.size() > 0 && evt_q[0].edge_n == ms.edge_n) begin
          mev = evt_q.pop_front();
          chk("pulses", 32'(mpul), 32'(mev.pulses), ms.edge_n);
        end else begin
          chk("unexpected_pulse", 32'(mpul), 32'h0, ms.edge_n);
        end
      end
    end
  end

  int t0, s0, rise_e;
  initial begin
    sys_init_ctrl_n = 1'b0;
    bus_if.btn_in   = 4'h0;
    bus_if.sw_in    = 4'h0;
    cur_raw         = 8'h00;
    model_reset();

    do_reset(5, 1'b1, 4'h0, 4'h0);
    hold(4'h0, 4'h0, 10);

    // Short trg glitch, then a proper trg hold
    hold(4'b0100, 4'h0, 3);
    hold(4'h0, 4'h0, 15);
    t0 = trg_seen;
    cycle(4'b0100, 4'h0);
    rise_e = e;
    hold(4'b0100, 4'h0, 29);
    hold(4'h0, 4'h0, 15);
    chk("trg_once", 32'(trg_seen - t0), 32'd1, e);
    chk("trg_delay", 32'(last_trg_edge - rise_e), 32'(DB + 2), e);

    // Run toggles twice, then once more, then run+rst together
    repeat (3) begin hold(4'b0001, 4'h0, 12); hold(4'h0, 4'h0, 12); end
    hold(4'b0011, 4'h0, 12);
    hold(4'h0, 4'h0, 12);

    // Switch change with a short glitch
    hold(4'h0, 4'b1010, 20);
    hold(4'h0, 4'b1111, 2);
    hold(4'h0, 4'b1010, 20);

    // Long rst hold with wrk_stat set beforehand
    hold(4'b0001, 4'b1010, 12);
    hold(4'h0, 4'b1010, 12);
    s0 = sinit_seen;
    hold(4'b0010, 4'b1010, 40);
    hold(4'h0, 4'b1010, 15);
    chk("long_sys_init", 32'(sinit_seen - s0), LONG_ON ? 32'd1 : 32'd0, e);

    // Reset in the middle of a debounce window
    hold(4'b0100, 4'b1010, 3);
    do_reset(3, 1'b0, 4'b0100, 4'b1010);
    hold(4'b0100, 4'b1010, 20);
    hold(4'h0, 4'h0, 15);

    random_run(700);
    do_reset(2, 1'b1, 4'h0, 4'h0);
    random_run(700);
    hold(4'h0, 4'h0, 20);
    chk("events_drained", 32'(evt_q.size()), 32'd0, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
